// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter and its BCD converter.
// Holds the default system clock rate, elaboration-time helper functions
// (ceiling log2 and powers of ten) and the measurement FSM encoding.
package freq_meter_pkg;

    localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;

    // GATE: counting, waiting for the end of the window
    // CONV: BCD conversion of the captured count in progress
    // DONE: results presented on the outputs for one cycle
    typedef enum logic [1:0] {
        GATE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } fm_state_t;

    // Smallest n such that 2**n >= value.
    function automatic int unsigned ceillog2(input longint unsigned value);
        int unsigned     n;
        longint unsigned p;
        n = 0;
        p = 1;
        while (p < value) begin
            p = p << 1;
            n = n + 1;
        end
        return n;
    endfunction

    function automatic longint unsigned pow10(input int unsigned exp10);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < exp10; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3, one bit
// per clock). A start pulse loads bin; COUNT_W cycles later done pulses
// for one cycle and bcd holds the result until the next start.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : load bin and begin converting
//   bin      : binary value, must be < 10**DIGITS
//   bcd      : packed BCD result, units digit in [3:0]
//   done     : one-cycle pulse after the final shift
module bin2bcd_seq
    import freq_meter_pkg::*;
#(
    parameter int unsigned COUNT_W = 20,
    parameter int unsigned DIGITS  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COUNT_W-1:0]    bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int unsigned CNT_W = ceillog2(COUNT_W + 1);

    logic [COUNT_W-1:0]  shift_q;
    logic [4*DIGITS-1:0] scratch_q;
    logic [4*DIGITS-1:0] scratch_d;
    logic [CNT_W-1:0]    bits_q;
    logic                running_q;
    logic                done_q;

    // Adjust every nibble >= 5 by +3, then shift the whole scratch left by
    // one, pulling in the next binary MSB. Each adjusted nibble's top bit
    // ripples into the bottom of the nibble above.
    always_comb begin
        logic [3:0] nib;
        logic       carry;
        scratch_d = '0;
        carry     = shift_q[COUNT_W-1];
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib = scratch_q[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            scratch_d[4*i +: 4] = {nib[2:0], carry};
            carry = nib[3];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            scratch_q <= '0;
            bits_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                shift_q   <= bin;
                scratch_q <= '0;
                bits_q    <= CNT_W'(COUNT_W);
                running_q <= 1'b1;
            end else if (running_q) begin
                scratch_q <= scratch_d;
                shift_q   <= shift_q << 1;
                bits_q    <= bits_q - CNT_W'(1);
                if (bits_q == CNT_W'(1)) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign bcd  = scratch_q;
    assign done = done_q;

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over a gate
// window of CLK_FREQ/GATE_HZ clocks, latches the count at the end of each
// window and converts it to packed BCD for the display path.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   sig_in   : asynchronous signal being measured
//   freq_bin : edge count of the last completed window (saturating)
//   bcd      : packed BCD of freq_bin, units digit in [3:0]
//   valid    : one-cycle pulse when freq_bin/bcd/overflow update
//   overflow : last window's count saturated at 10**DIGITS-1
//   busy     : conversion in progress (CONV or DONE)
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter  int unsigned CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter  int unsigned GATE_HZ  = 1,
    parameter  int unsigned DIGITS   = 6,
    localparam int unsigned COUNT_W  = ceillog2(pow10(DIGITS))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sig_in,
    output logic [COUNT_W-1:0]    freq_bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valid,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned     GATE_CYCLES = CLK_FREQ / GATE_HZ;
    localparam int unsigned     GATE_W      = ceillog2(GATE_CYCLES);
    localparam longint unsigned MAX_COUNT   = pow10(DIGITS) - 1;

    // A conversion must finish before the next window closes.
    if (GATE_CYCLES < COUNT_W + 4) begin : g_gate_too_short
        $error("freq_meter: GATE_CYCLES must be at least COUNT_W+4");
    end

    // Input synchronizer plus edge-detect stage.
    logic s1_q, s2_q, s3_q;
    logic sig_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sig_edge = s2_q & ~s3_q;

    // Free-running gate counter.
    logic [GATE_W-1:0] gate_cnt_q;
    logic              tc;

    assign tc = (gate_cnt_q == GATE_W'(GATE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt_q <= '0;
        end else if (tc) begin
            gate_cnt_q <= '0;
        end else begin
            gate_cnt_q <= gate_cnt_q + GATE_W'(1);
        end
    end

    // Saturating edge counter. An edge on the terminal cycle is folded into
    // the captured value so the closing window keeps it, and the counter
    // restarts from zero on that same clock.
    logic [COUNT_W-1:0] edge_cnt_q;
    logic               sat_q;
    logic               at_max;
    logic [COUNT_W-1:0] capture;
    logic               capture_sat;

    assign at_max      = (edge_cnt_q == COUNT_W'(MAX_COUNT));
    assign capture     = edge_cnt_q + COUNT_W'(sig_edge & ~at_max);
    assign capture_sat = sat_q | (sig_edge & at_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
        end else if (tc) begin
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
        end else if (sig_edge) begin
            if (at_max) begin
                sat_q <= 1'b1;
            end else begin
                edge_cnt_q <= edge_cnt_q + COUNT_W'(1);
            end
        end
    end

    // Measurement FSM.
    fm_state_t state_q, state_d;
    logic      conv_start;
    logic      conv_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        case (state_q)
            GATE: begin
                if (tc) begin
                    conv_start = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = GATE;
            end
            default: begin
                state_d = GATE;
            end
        endcase
    end

    // Captured window result waits here while the converter runs.
    logic [COUNT_W-1:0]  cap_bin_q;
    logic                cap_sat_q;
    logic [4*DIGITS-1:0] conv_bcd;

    bin2bcd_seq #(
        .COUNT_W (COUNT_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (capture),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_bin_q <= '0;
            cap_sat_q <= 1'b0;
        end else if (conv_start) begin
            cap_bin_q <= capture;
            cap_sat_q <= capture_sat;
        end
    end

    // Outputs load together as the FSM enters DONE, so they are stable
    // during the valid cycle and hold until the next window's result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_bin <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else if (state_q == CONV && conv_done) begin
            freq_bin <= cap_bin_q;
            bcd      <= conv_bcd;
            overflow <= cap_sat_q;
        end
    end

    assign valid = (state_q == DONE);
    assign busy  = (state_q != GATE);

endmodule
